// File: rtl/fb_scan_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fb_scan_arbiter
//  Brief    : Shares the single-port 160x144 2bpp framebuffer RAM between
//             4x/3x scaled display scan-out (fixed read slot, absolute
//             priority) and PPU writes (req/ack, at most one per 2 cycles).
//  Options  : FB_TESTPATTERN_EN adds input test_pat; while high, pix shows
//             (col + row) mod 4 and no read slots are issued.
//  Revision : 1.0  initial release
// ============================================================================
module fb_scan_arbiter #(
   parameter int GB_W   = 160,
   parameter int GB_H   = 144,
   parameter int YSCALE = 3,
   parameter int ADDR_W = 15
) (
   input  logic              fbclk,
   input  logic              rst,
`ifdef FB_TESTPATTERN_EN
   input  logic              test_pat,
`endif
   input  logic [11:0]       x,
   input  logic [11:0]       y,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [1:0]        wr_data,
   output logic              wr_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [1:0]        mem_wdata,
   input  logic [1:0]        mem_rdata,
   output logic [1:0]        pix,
   output logic              pix_active
);

   localparam int SUB_W = (YSCALE > 1) ? $clog2(YSCALE) : 1;
   localparam int ROW_W = $clog2(GB_H + 1);

   localparam logic [11:0]       c_img_w    = 12'(GB_W * 4);
   localparam logic [11:0]       c_img_h    = 12'(GB_H * YSCALE);
   localparam logic [11:0]       c_last_x   = 12'(GB_W * 4 - 1);
   localparam logic [ADDR_W-1:0] c_fb_size  = ADDR_W'(GB_W * GB_H);
   localparam logic [ADDR_W-1:0] c_row_step = ADDR_W'(GB_W);
   localparam logic [SUB_W-1:0]  c_sub_last = SUB_W'(YSCALE - 1);

   // Row tracking state
   logic [ADDR_W-1:0] r_row_base;
   logic [SUB_W-1:0]  r_sub;
   logic [ROW_W-1:0]  r_gb_row;

   // Scan-out pipeline state
   logic       r_rd_p1, r_rd_p2;
   logic       r_act_p1, r_act_p2;
   logic       r_tp_p1, r_tp_p2;
   logic [1:0] r_tpv_p1, r_tpv_p2;

   logic              w_test;
   logic              w_frame_start;
   logic              w_image;
   logic              w_line_end;
   logic              w_read_slot;
   logic              w_grant;
   logic              w_wr_in_range;
   logic [ADDR_W-1:0] w_row_base;
   logic [SUB_W-1:0]  w_sub;
   logic [ROW_W-1:0]  w_gb_row;
   logic [ADDR_W-1:0] w_rd_addr;
   logic [1:0]        w_tp_val;

`ifdef FB_TESTPATTERN_EN
   assign w_test = test_pat;
`else
   assign w_test = 1'b0;
`endif

   assign w_frame_start = (x == 12'd0) && (y == 12'd0);
   assign w_image       = (x < c_img_w) && (y < c_img_h);
   assign w_line_end    = (x == c_last_x) && (y < c_img_h);

   // The frame-start reset of the row tracker takes effect in the same cycle
   // so the read issued at raster (0,0) already uses row 0.
   assign w_row_base = w_frame_start ? '0 : r_row_base;
   assign w_sub      = w_frame_start ? '0 : r_sub;
   assign w_gb_row   = w_frame_start ? '0 : r_gb_row;

   assign w_read_slot   = w_image && (x[1:0] == 2'b00) && !w_test;
   // A request is never granted in its own ack cycle.
   assign w_grant       = !w_read_slot && wr_req && !wr_ack;
   assign w_wr_in_range = (wr_addr < c_fb_size);
   assign w_rd_addr     = w_row_base + ADDR_W'(x[11:2]);
   assign w_tp_val      = x[3:2] + w_gb_row[1:0];

   // Advance the Game Boy row every YSCALE image lines; restart at frame start
   always_ff @(posedge fbclk or posedge rst) begin
      if (rst) begin
         r_row_base <= '0;
         r_sub      <= '0;
         r_gb_row   <= '0;
      end else if (w_line_end) begin
         if (w_sub == c_sub_last) begin
            r_sub      <= '0;
            r_row_base <= w_row_base + c_row_step;
            r_gb_row   <= w_gb_row + ROW_W'(1);
         end else begin
            r_sub      <= w_sub + SUB_W'(1);
            r_row_base <= w_row_base;
            r_gb_row   <= w_gb_row;
         end
      end else if (w_frame_start) begin
         r_row_base <= '0;
         r_sub      <= '0;
         r_gb_row   <= '0;
      end
   end

   // RAM port arbitration: read slot first, then a pending write, else idle
   always_ff @(posedge fbclk or posedge rst) begin
      if (rst) begin
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= 2'd0;
         wr_ack    <= 1'b0;
      end else if (w_read_slot) begin
         mem_addr <= w_rd_addr;
         mem_we   <= 1'b0;
         wr_ack   <= 1'b0;
      end else if (w_grant) begin
         // Out-of-range writes are acknowledged but never reach the RAM.
         mem_addr  <= wr_addr;
         mem_wdata <= wr_data;
         mem_we    <= w_wr_in_range;
         wr_ack    <= 1'b1;
      end else begin
         mem_we <= 1'b0;
         wr_ack <= 1'b0;
      end
   end

   // Three-stage scan-out pipeline: address, RAM data, pixel capture
   always_ff @(posedge fbclk or posedge rst) begin
      if (rst) begin
         r_rd_p1    <= 1'b0;
         r_rd_p2    <= 1'b0;
         r_act_p1   <= 1'b0;
         r_act_p2   <= 1'b0;
         r_tp_p1    <= 1'b0;
         r_tp_p2    <= 1'b0;
         r_tpv_p1   <= 2'd0;
         r_tpv_p2   <= 2'd0;
         pix_active <= 1'b0;
         pix        <= 2'd0;
      end else begin
         r_rd_p1    <= w_read_slot;
         r_rd_p2    <= r_rd_p1;
         r_act_p1   <= w_image;
         r_act_p2   <= r_act_p1;
         r_tp_p1    <= w_test;
         r_tp_p2    <= r_tp_p1;
         r_tpv_p1   <= w_tp_val;
         r_tpv_p2   <= r_tpv_p1;
         pix_active <= r_act_p2;
         if (!r_act_p2) begin
            pix <= 2'd0;
         end else if (r_tp_p2) begin
            pix <= r_tpv_p2;
         end else if (r_rd_p2) begin
            pix <= mem_rdata;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fb_scan_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fb_scan_arbiter
//  Brief    : Directed self-checking bench for fb_scan_arbiter with a
//             1-cycle synchronous RAM model preloaded with addr mod 4.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fb_scan_arbiter;

   logic        fbclk = 1'b0;
   logic        rst;
   logic [11:0] x;
   logic [11:0] y;
   logic        wr_req;
   logic [14:0] wr_addr;
   logic [1:0]  wr_data;
   logic        wr_ack;
   logic [14:0] mem_addr;
   logic        mem_we;
   logic [1:0]  mem_wdata;
   logic [1:0]  mem_rdata;
   logic [1:0]  pix;
   logic        pix_active;

   int checks = 0;
   int passes = 0;

   logic [1:0] ram [0:32767];
   logic       ram_ready = 1'b0;

   fb_scan_arbiter dut (
      .fbclk      (fbclk),
      .rst        (rst),
      .x          (x),
      .y          (y),
      .wr_req     (wr_req),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_ack     (wr_ack),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .pix        (pix),
      .pix_active (pix_active)
   );

   always #5 fbclk = ~fbclk;

   // Synchronous single-port RAM, preloaded with addr mod 4 on the first edge
   always @(posedge fbclk) begin
      if (!ram_ready) begin
         for (int i = 0; i < 32768; i++) ram[i] <= 2'(i);
         ram_ready <= 1'b1;
      end else if (mem_we) begin
         ram[mem_addr] <= mem_wdata;
      end
      mem_rdata <= ram[mem_addr];
   end

   // One raster position per clock; outputs are sampled 1 time unit after the edge
   task automatic step(input logic [11:0] xx, input logic [11:0] yy);
      x = xx;
      y = yy;
      @(posedge fbclk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = 2'd0;
      for (int i = 0; i < 4; i++) step(12'(i), 12'd0);
      checks++;
      if ({wr_ack, mem_we, mem_addr, mem_wdata, pix, pix_active} !== 22'd0)
         $display("FAIL reset_outputs got ack=%0d we=%0d addr=%0d wd=%0d pix=%0d act=%0d want all 0",
                  wr_ack, mem_we, mem_addr, mem_wdata, pix, pix_active);
      else passes++;
      rst = 1'b0;
   endtask

   task automatic test_scan();
      for (int yy = 0; yy < 525; yy++) begin
         if (yy == 0 || yy == 2 || yy == 3 || yy == 431 || yy == 432) begin
            for (int xx = 0; xx < 800; xx++) begin
               step(12'(xx), 12'(yy));
               if (yy == 0 && xx >= 2 && xx <= 5) begin
                  checks++;
                  if (pix !== 2'd0 || pix_active !== 1'b1)
                     $display("FAIL scan_0_0 x=%0d pix=%0d act=%0d want pix=0 act=1", xx, pix, pix_active);
                  else passes++;
               end
               if (yy == 0 && xx == 4) begin
                  checks++;
                  if (mem_addr !== 15'd1 || mem_we !== 1'b0)
                     $display("FAIL scan_addr_4_0 addr=%0d we=%0d want 1/0", mem_addr, mem_we);
                  else passes++;
               end
               if (yy == 0 && (xx == 6 || xx == 9)) begin
                  checks++;
                  if (pix !== 2'd1)
                     $display("FAIL scan_4_0 x=%0d pix=%0d want 1", xx, pix);
                  else passes++;
               end
               if (yy == 0 && xx == 10) begin
                  checks++;
                  if (pix !== 2'd2) $display("FAIL scan_8_0 pix=%0d want 2", pix);
                  else passes++;
               end
               if (yy == 0 && xx == 641) begin
                  checks++;
                  if (pix !== 2'd3 || pix_active !== 1'b1)
                     $display("FAIL scan_639_0 pix=%0d act=%0d want 3/1", pix, pix_active);
                  else passes++;
               end
               if (yy == 0 && xx == 642) begin
                  checks++;
                  if (pix !== 2'd0 || pix_active !== 1'b0)
                     $display("FAIL scan_640_0 pix=%0d act=%0d want 0/0", pix, pix_active);
                  else passes++;
               end
               if (yy == 2 && xx == 0) begin
                  checks++;
                  if (mem_addr !== 15'd0) $display("FAIL scan_addr_0_2 addr=%0d want 0", mem_addr);
                  else passes++;
               end
               if (yy == 3 && xx == 0) begin
                  checks++;
                  if (mem_addr !== 15'd160) $display("FAIL scan_addr_0_3 addr=%0d want 160", mem_addr);
                  else passes++;
               end
               if (yy == 3 && xx == 2) begin
                  checks++;
                  if (pix !== 2'd0) $display("FAIL scan_0_3 pix=%0d want 0", pix);
                  else passes++;
               end
               if (yy == 3 && xx == 6) begin
                  checks++;
                  if (pix !== 2'd1) $display("FAIL scan_4_3 pix=%0d want 1", pix);
                  else passes++;
               end
               if (yy == 431 && xx == 636) begin
                  checks++;
                  if (mem_addr !== 15'd23039) $display("FAIL scan_addr_636_431 addr=%0d want 23039", mem_addr);
                  else passes++;
               end
               if (yy == 431 && xx == 638) begin
                  checks++;
                  if (pix !== 2'd3 || pix_active !== 1'b1)
                     $display("FAIL scan_636_431 pix=%0d act=%0d want 3/1", pix, pix_active);
                  else passes++;
               end
               if (yy == 432 && xx == 0) begin
                  checks++;
                  if (mem_addr !== 15'd23039) $display("FAIL scan_no_read_432 addr=%0d want 23039", mem_addr);
                  else passes++;
               end
               if (yy == 432 && xx == 5) begin
                  checks++;
                  if (pix_active !== 1'b0 || pix !== 2'd0)
                     $display("FAIL scan_border_432 pix=%0d act=%0d want 0/0", pix, pix_active);
                  else passes++;
               end
            end
         end else begin
            step(12'd639, 12'(yy));
         end
      end
   endtask

   task automatic test_write_collision();
      step(12'd0, 12'd0);
      for (int yy = 0; yy < 5; yy++) step(12'd639, 12'(yy));
      for (int xx = 0; xx < 8; xx++) step(12'(xx), 12'd5);
      wr_req = 1'b1; wr_addr = 15'd100; wr_data = 2'd2;
      step(12'd8, 12'd5);
      checks++;
      if (wr_ack !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 15'd162)
         $display("FAIL collide_read ack=%0d we=%0d addr=%0d want 0/0/162", wr_ack, mem_we, mem_addr);
      else passes++;
      step(12'd9, 12'd5);
      checks++;
      if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'd100 || mem_wdata !== 2'd2)
         $display("FAIL collide_write ack=%0d we=%0d addr=%0d wd=%0d want 1/1/100/2",
                  wr_ack, mem_we, mem_addr, mem_wdata);
      else passes++;
      wr_req = 1'b0;
      step(12'd10, 12'd5);
      checks++;
      if (wr_ack !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 15'd100)
         $display("FAIL collide_idle ack=%0d we=%0d addr=%0d want 0/0/100", wr_ack, mem_we, mem_addr);
      else passes++;
      step(12'd11, 12'd5);
   endtask

   task automatic test_back_to_back();
      int   a = 0;
      int   acks = 0;
      logic prev_ack = 1'b0;
      for (int xx = 12; xx < 52; xx++) begin
         wr_req = 1'b1; wr_addr = 15'(a); wr_data = 2'(a);
         step(12'(xx), 12'd5);
         checks++;
         if (wr_ack && prev_ack) $display("FAIL b2b_consecutive_ack x=%0d ack=1 prev=1 want not both", xx);
         else passes++;
         if (xx % 4 == 0) begin
            checks++;
            if (mem_we !== 1'b0 || mem_addr !== 15'(160 + xx / 4))
               $display("FAIL b2b_read_slot x=%0d we=%0d addr=%0d want 0/%0d", xx, mem_we, mem_addr, 160 + xx / 4);
            else passes++;
         end
         if (xx >= 14) begin
            checks++;
            if (pix !== 2'((xx - 2) >> 2) || pix_active !== 1'b1)
               $display("FAIL b2b_pix x=%0d pix=%0d act=%0d want %0d/1", xx, pix, pix_active, ((xx - 2) >> 2) & 3);
            else passes++;
         end
         if (wr_ack) begin
            a++;
            acks++;
         end
         prev_ack = wr_ack;
      end
      wr_req = 1'b0;
      checks++;
      if (acks != 20) $display("FAIL b2b_ack_count got=%0d want 20", acks);
      else passes++;
      step(12'd52, 12'd5);
   endtask

   task automatic test_free_write();
      wr_req = 1'b1; wr_addr = 15'd200; wr_data = 2'd0;
      step(12'd0, 12'd500);
      checks++;
      if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'd200)
         $display("FAIL free_write ack=%0d we=%0d addr=%0d want 1/1/200", wr_ack, mem_we, mem_addr);
      else passes++;
      wr_addr = 15'd204;
      step(12'd1, 12'd500);
      checks++;
      if (wr_ack !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 15'd200)
         $display("FAIL free_no_regrant ack=%0d we=%0d addr=%0d want 0/0/200", wr_ack, mem_we, mem_addr);
      else passes++;
      step(12'd2, 12'd500);
      checks++;
      if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'd204)
         $display("FAIL free_second ack=%0d we=%0d addr=%0d want 1/1/204", wr_ack, mem_we, mem_addr);
      else passes++;
      wr_req = 1'b0;
      step(12'd3, 12'd500);
   endtask

   task automatic test_out_of_range();
      wr_req = 1'b1; wr_addr = 15'd23040; wr_data = 2'd1;
      step(12'd4, 12'd500);
      checks++;
      if (wr_ack !== 1'b1 || mem_we !== 1'b0)
         $display("FAIL oor_23040 ack=%0d we=%0d want 1/0", wr_ack, mem_we);
      else passes++;
      wr_req = 1'b0;
      step(12'd5, 12'd500);
      wr_req = 1'b1; wr_addr = 15'd23039; wr_data = 2'd3;
      step(12'd6, 12'd500);
      checks++;
      if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'd23039 || mem_wdata !== 2'd3)
         $display("FAIL inrange_23039 ack=%0d we=%0d addr=%0d wd=%0d want 1/1/23039/3",
                  wr_ack, mem_we, mem_addr, mem_wdata);
      else passes++;
      wr_req = 1'b0;
      step(12'd7, 12'd500);
   endtask

   task automatic test_reset_mid();
      for (int xx = 190; xx < 200; xx++) step(12'(xx), 12'd100);
      x = 12'd200;
      wr_req = 1'b1; wr_addr = 15'd300; wr_data = 2'd3;
      rst = 1'b1;
      #2;
      checks++;
      if ({wr_ack, mem_we, mem_addr, mem_wdata, pix, pix_active} !== 22'd0)
         $display("FAIL rst_async ack=%0d we=%0d addr=%0d wd=%0d pix=%0d act=%0d want all 0",
                  wr_ack, mem_we, mem_addr, mem_wdata, pix, pix_active);
      else passes++;
      @(posedge fbclk);
      #1;
      checks++;
      if (wr_ack !== 1'b0 || mem_we !== 1'b0)
         $display("FAIL rst_no_write ack=%0d we=%0d want 0/0", wr_ack, mem_we);
      else passes++;
      rst = 1'b0;
      step(12'd201, 12'd100);
      checks++;
      if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'd300 || mem_wdata !== 2'd3)
         $display("FAIL rst_write_after ack=%0d we=%0d addr=%0d wd=%0d want 1/1/300/3",
                  wr_ack, mem_we, mem_addr, mem_wdata);
      else passes++;
      wr_req = 1'b0;
      for (int yy = 100; yy < 104; yy++) step(12'd639, 12'(yy));
      for (int xx = 0; xx < 8; xx++) begin
         step(12'(xx), 12'd0);
         if (xx == 0 || xx == 4) begin
            checks++;
            if (mem_addr !== 15'(xx / 4))
               $display("FAIL rst_realign_addr x=%0d addr=%0d want %0d", xx, mem_addr, xx / 4);
            else passes++;
         end
         if (xx == 2) begin
            checks++;
            if (pix !== 2'd0 || pix_active !== 1'b1)
               $display("FAIL rst_realign_pix0 pix=%0d act=%0d want 0/1", pix, pix_active);
            else passes++;
         end
         if (xx == 6) begin
            checks++;
            if (pix !== 2'd1 || pix_active !== 1'b1)
               $display("FAIL rst_realign_pix1 pix=%0d act=%0d want 1/1", pix, pix_active);
            else passes++;
         end
      end
   endtask

   initial begin
      x = '0; y = '0;
      test_reset();
      test_scan();
      test_write_collision();
      test_back_to_back();
      test_free_write();
      test_out_of_range();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
